// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage LEGv8 core. Each cycle it
// decides whether the PC and the IF/ID and ID/EX pipeline registers advance,
// stall, bubble or flush. It handles three cases: load-use hazards, taken-branch
// squashes, and multi-cycle EX operations. A watchdog guards the multi-cycle
// wait.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_count saturating performance counters.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   id_valid                ID holds a real instruction
//   id_rn, id_rm            ID source registers
//   id_uses_rn, id_uses_rm  ID source actually read
//   ex_valid                EX holds a real instruction
//   ex_rd                   EX destination register
//   ex_mem_read             EX instruction is a load
//   ex_mc_start             EX instruction is a multi-cycle op
//   mc_done                 multi-cycle result valid this cycle
//   br_taken                EX branch resolved taken
//   pc_write                PC may update                 (combinational)
//   ifid_write              IF/ID may load                (combinational)
//   ifid_flush              IF/ID loads a NOP             (combinational)
//   idex_write              ID/EX may load                (combinational)
//   idex_bubble             ID/EX loads a NOP             (combinational)
//   busy                    waiting on a multi-cycle op   (combinational)
//   mc_timeout              sticky watchdog error         (registered)
//   stall_cycles            cycles with pc_write low      (HAZARD_PERF_CNT_EN)
//   flush_count             cycles with ifid_flush high   (HAZARD_PERF_CNT_EN)
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_uses_rn,
    input  logic                id_uses_rm,
    input  logic                ex_valid,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_mc_start,
    input  logic                mc_done,
    input  logic                br_taken,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                idex_write,
    output logic                idex_bubble,
    output logic                busy,
    output logic                mc_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_count
`endif
);

    localparam int unsigned TMR_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mc_timeout_q, mc_timeout_d;
    logic               lu_hazard;
    logic               run_decode;

    // Load-use: a load in EX writes a register the ID instruction reads.
    assign lu_hazard = ex_valid && ex_mem_read && (ex_rd != REG_BITS'(ZERO_REG)) &&
                       id_valid &&
                       ((id_uses_rn && (id_rn == ex_rd)) ||
                        (id_uses_rm && (id_rm == ex_rd)));

    // While reset is high the outputs follow the RUN decode regardless of state.
    assign run_decode = reset || (state_q == ST_RUN);

    // Next-state and Mealy output decode.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mc_timeout_d = mc_timeout_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        busy         = !run_decode;

        if (run_decode) begin
            if (ex_mc_start && !mc_done) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
                state_d    = ST_MC_WAIT;
                timer_d    = TMR_W'(1);
            end else if (br_taken) begin
                // Squashes both the fetched and the decoded instruction.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu_hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end else begin
            if (mc_done) begin
                state_d = ST_RUN;
            end else if (timer_q == TMR_W'(MC_TIMEOUT)) begin
                // Watchdog expired: abandon the wait and release as if done.
                mc_timeout_d = 1'b1;
                state_d      = ST_RUN;
            end else begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
                if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        end
    end

    // State, watchdog timer and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            timer_q      <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ifid_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Expected output vectors are pushed to a
// scoreboard queue when stimulus is applied and popped at the following
// negative clock edge. Output vector order:
// {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, busy, mc_timeout}
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm;
    logic       id_uses_rn, id_uses_rm;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_mem_read, ex_mc_start, mc_done, br_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic       busy, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(
        .REG_BITS   (5),
        .ZERO_REG   (31),
        .MC_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rn  (id_uses_rn),
        .id_uses_rm  (id_uses_rm),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_mc_start (ex_mc_start),
        .mc_done     (mc_done),
        .br_taken    (br_taken),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_write  (idex_write),
        .idex_bubble (idex_bubble),
        .busy        (busy),
        .mc_timeout  (mc_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       idv;
        logic [4:0] rn;
        logic       urn;
        logic [4:0] rm;
        logic       urm;
        logic       exv;
        logic [4:0] rd;
        logic       mr;
        logic       mcs;
        logic       mcd;
        logic       br;
    } stim_t;

    // Expected output encodings.
    localparam logic [6:0] O_RUN    = 7'b1101000;
    localparam logic [6:0] O_FRZ    = 7'b0000000;
    localparam logic [6:0] O_FRZ_W  = 7'b0000010;
    localparam logic [6:0] O_REL_W  = 7'b1101010;
    localparam logic [6:0] O_BR     = 7'b1111100;
    localparam logic [6:0] O_LU     = 7'b0001100;

    logic [6:0] exp_q[$];
    int unsigned vectors;
    int unsigned miscompares;
    logic [6:0] got;
    logic [6:0] exp_v;

    function automatic stim_t st(input logic rst, input logic idv,
                                 input logic [4:0] rn, input logic urn,
                                 input logic [4:0] rm, input logic urm,
                                 input logic exv, input logic [4:0] rd,
                                 input logic mr, input logic mcs,
                                 input logic mcd, input logic br);
        stim_t s;
        s.rst = rst; s.idv = idv; s.rn = rn; s.urn = urn; s.rm = rm; s.urm = urm;
        s.exv = exv; s.rd = rd; s.mr = mr; s.mcs = mcs; s.mcd = mcd; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    endfunction

    // Apply one cycle of stimulus after the rising edge and queue its expectation.
    task automatic drive(input stim_t s, input logic [6:0] e);
        @(posedge clk);
        #1;
        reset       = s.rst;
        id_valid    = s.idv;
        id_rn       = s.rn;
        id_uses_rn  = s.urn;
        id_rm       = s.rm;
        id_uses_rm  = s.urm;
        ex_valid    = s.exv;
        ex_rd       = s.rd;
        ex_mem_read = s.mr;
        ex_mc_start = s.mcs;
        mc_done     = s.mcd;
        br_taken    = s.br;
        exp_q.push_back(e);
    endtask

    function automatic logic [6:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, busy, mc_timeout};
    endfunction

    task automatic test_reset();
        stim_t s[3];
        logic [6:0] e[3];
        s[0] = st(1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);  e[0] = O_RUN;
        s[1] = st(1, 1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 1, 0, 0, 0);  e[1] = O_LU;
        s[2] = idle();                                          e[2] = O_RUN;
        for (int i = 0; i < 3; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[5];
        logic [6:0] e[5];
        s[0] = st(0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0);  e[0] = O_LU;
        s[1] = st(0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);  e[1] = O_RUN;
        s[2] = st(0, 1, 5'd1, 1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0);  e[2] = O_LU;
        s[3] = st(0, 1, 5'd9, 0, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0);  e[3] = O_RUN;
        s[4] = st(0, 0, 5'd9, 1, 5'd0, 0, 1, 5'd9, 1, 0, 0, 0);  e[4] = O_RUN;
        for (int i = 0; i < 5; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL load_use[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_xzr();
        stim_t s[2];
        logic [6:0] e[2];
        s[0] = st(0, 1, 5'd0, 0, 5'd31, 1, 1, 5'd31, 1, 0, 0, 0); e[0] = O_RUN;
        s[1] = st(0, 1, 5'd8, 1, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0);   e[1] = O_RUN;
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL xzr[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_branch_hazard();
        stim_t s[2];
        logic [6:0] e[2];
        s[0] = st(0, 1, 5'd4, 1, 5'd0, 0, 1, 5'd4, 1, 0, 0, 1);  e[0] = O_BR;
        s[1] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 1, 1);  e[1] = O_BR;
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL branch_hazard[%0d] got %b expected %b", i, got, exp_v);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #1;
        vectors++;
        if (flush_count !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_count got %0d expected 2", flush_count);
        end
`endif
    endtask

    task automatic test_multicycle();
        stim_t s[6];
        logic [6:0] e[6];
        s[0] = st(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);  e[0] = O_RUN;
        s[1] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 0, 1);  e[1] = O_FRZ;
        s[2] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0);  e[2] = O_FRZ_W;
        s[3] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0);  e[3] = O_FRZ_W;
        s[4] = st(0, 1, 5'd6, 1, 5'd0, 0, 1, 5'd6, 1, 1, 1, 1);  e[4] = O_REL_W;
        s[5] = idle();                                          e[5] = O_RUN;
        for (int i = 0; i < 6; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL multicycle[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[5];
        logic [6:0] e[5];
        s[0] = st(0, 1, 5'd7, 1, 5'd0, 0, 1, 5'd7, 1, 0, 0, 0);  e[0] = O_LU;
        s[1] = st(0, 1, 5'd0, 0, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0);  e[1] = O_LU;
        s[2] = st(0, 1, 5'd7, 1, 5'd0, 0, 1, 5'd7, 1, 0, 0, 1);  e[2] = O_BR;
        s[3] = st(0, 1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 1, 1, 1, 0);  e[3] = O_LU;
        s[4] = idle();                                          e[4] = O_RUN;
        for (int i = 0; i < 5; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s[7];
        logic [6:0] e[7];
        s[0] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0);  e[0] = O_FRZ;
        s[1] = s[0];                                            e[1] = O_FRZ_W;
        s[2] = s[0];                                            e[2] = O_FRZ_W;
        s[3] = s[0];                                            e[3] = O_FRZ_W;
        s[4] = idle();                                          e[4] = O_REL_W;
        s[5] = idle();                                          e[5] = O_RUN | 7'b0000001;
        s[6] = st(0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0);  e[6] = O_LU | 7'b0000001;
        for (int i = 0; i < 7; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL timeout[%0d] got %b expected %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t s[4];
        logic [6:0] e[4];
        s[0] = st(0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd2, 0, 1, 0, 0);  e[0] = O_FRZ | 7'b0000001;
        s[1] = s[0];                                            e[1] = O_FRZ_W | 7'b0000001;
        s[2] = st(1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);  e[2] = O_RUN | 7'b0000001;
        s[3] = idle();                                          e[3] = O_RUN;
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got = outs(); exp_v = exp_q.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_wait[%0d] got %b expected %b", i, got, exp_v);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_after_reset got stall=%0d flush=%0d expected 0 0",
                     stall_cycles, flush_count);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        id_valid    = 1'b0;
        id_rn       = '0;
        id_rm       = '0;
        id_uses_rn  = 1'b0;
        id_uses_rm  = 1'b0;
        ex_valid    = 1'b0;
        ex_rd       = '0;
        ex_mem_read = 1'b0;
        ex_mc_start = 1'b0;
        mc_done     = 1'b0;
        br_taken    = 1'b0;

        test_reset();
        test_load_use();
        test_xzr();
        test_branch_hazard();
        test_multicycle();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage LEGv8 core. Sits beside the IF/ID and ID/EX pipeline registers and decides each cycle whether the PC and pipeline registers advance, stall, bubble or flush. It covers three cases: load-use hazards, taken-branch squashes, and multi-cycle EX operations such as the multiplier. It contains a small FSM with a watchdog timer, and optional performance counters.

## Interface
Parameters:
- REG_BITS, 5, register-specifier width
- ZERO_REG, 31, index of XZR (never a hazard source)
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before abandon

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rn, id_rm  in  REG_BITS  ID source registers
- id_uses_rn, id_uses_rm  in  1  source actually read
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_BITS  EX destination register
- ex_mem_read  in  1  EX instruction is a load (LDUR)
- ex_mc_start  in  1  EX instruction is a multi-cycle op
- mc_done  in  1  multi-cycle unit result valid this cycle
- br_taken  in  1  branch in EX resolved taken
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX may load
- idex_bubble  out  1  ID/EX loads a NOP (control zeroed)
- busy  out  1  FSM not in RUN
- mc_timeout  out  1  sticky watchdog error

## Operation
- FSM states: RUN, MC_WAIT. Reset state is RUN.
- Outputs are decoded from the current state and the inputs (Mealy, combinational). Default in RUN: pc_write=ifid_write=idex_write=1, ifid_flush=idex_bubble=0.
- lu_hazard = ex_valid & ex_mem_read & ex_rd!=ZERO_REG & id_valid & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
- Priority in RUN, highest first:
  1. ex_mc_start & !mc_done: freeze. pc_write=ifid_write=idex_write=0. Next state is MC_WAIT and the timer loads 1. br_taken is ignored this cycle.
  2. br_taken: ifid_flush=1, idex_bubble=1, pc_write=1 (target loads). Any lu_hazard is ignored because the ID instruction is squashed.
  3. lu_hazard: pc_write=0, ifid_write=0, idex_bubble=1. This inserts exactly one bubble; the next cycle re-evaluates, with EX now holding the bubble.
- ex_mc_start with mc_done in the same RUN cycle: no freeze, stay in RUN, then apply rules 2–3.
- MC_WAIT behaviour:
  - Without mc_done: freeze as above and increment the timer.
  - With mc_done: advance normally (RUN defaults, br_taken and lu_hazard ignored). Next state is RUN.
  - When the timer equals MC_TIMEOUT without mc_done: set mc_timeout, release as if mc_done, and go to RUN.
- mc_done in RUN (other than the same-cycle case) is ignored.
- busy = (state==MC_WAIT).
- mc_timeout clears only on reset.

## Timing
- Reset values: state RUN, timer 0, mc_timeout 0, counters 0. During reset, outputs show the RUN decode of the inputs.
- Load-use penalty is exactly 1 cycle. Branch penalty is 2 squashed instructions (IF/ID and ID/EX) in one cycle.
- Multi-cycle op with mc_done k cycles after entry costs k+1 frozen cycles counted from ex_mc_start. Release happens in the mc_done cycle.
- Timer width is $clog2(MC_TIMEOUT+1). It saturates and never wraps.
- Reset asserted mid-MC_WAIT returns to RUN on the next edge; no release pulse is generated.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- HAZARD_PERF_CNT_EN not defined: ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rn=5, id_uses_rn=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Next cycle with ex_valid=0 -> all advance.
- XZR load: ex_rd=31 matching id_rm=31 -> no stall.
- Branch plus hazard in the same cycle: br_taken=1 and lu_hazard=1 -> ifid_flush=1, idex_bubble=1, pc_write=1. flush_count increments by 1.
- Multi-cycle: ex_mc_start=1, mc_done three cycles later -> freeze for 3 cycles, busy=1, release in the mc_done cycle, state RUN next cycle.
- Timeout: MC_TIMEOUT=4, mc_done never asserted -> mc_timeout=1 after the 4th MC_WAIT cycle, release, return to RUN. mc_timeout stays high until reset.
- Reset mid-MC_WAIT: assert reset for 1 cycle -> busy=0, mc_timeout=0, and stall_cycles=0 if enabled.
